mmio_ctrl: RTL and testbench
============================

Name: mmio_ctrl

Overview:
Memory-mapped I/O controller for the RISC-V core's 0x8xxx_xxxx region. It is driven by the execute-stage memory request and owns the UART ready/valid handshakes and the cycle/instruction counters. It registers read data and the address-region nibble into the writeback stage, and drives the writeback selector's uart_out and mem_out_sel inputs.

Parameters:
CNT_W, 32, counter width; counters zero-extended to 32 bits on read (CNT_W ≤ 32).
TX_DROP_ON_BUSY, 1, 1 = a TX write while pending is silently dropped; 0 = the new byte overwrites the pending byte.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
stall  in  1  pipeline stall; freezes writeback-facing registers and suppresses side effects
req_addr  in  32  execute-stage byte address
req_re  in  1  load request
req_we  in  1  store request
req_wdata  in  32  store data
instr_retire  in  1  one instruction retired this cycle
uart_rx_data  in  8  received byte
uart_rx_valid  in  1  RX byte available
uart_rx_ready  out  1  pop RX byte (combinational)
uart_tx_data  out  8  byte to transmit
uart_tx_valid  out  1  TX byte pending
uart_tx_ready  in  1  UART accepts TX byte
uart_out  out  32  registered MMIO read data for writeback
mem_out_sel  out  4  registered req_addr[31:28] for writeback select

Behaviour:
- Reset (async, rst=1): uart_out=0, mem_out_sel=0, tx_pending=0, uart_tx_data=0, cycle_cnt=0, instr_cnt=0. uart_rx_ready and uart_tx_valid are therefore 0.
- hit = (req_addr[31:28]==4'b1000). Offsets are decoded on req_addr[7:0]; req_addr[1:0] are ignored.
- Address map:
  - 0x00 R status = {30'b0, uart_rx_valid, ~tx_pending}.
  - 0x04 R rx data = {24'b0, uart_rx_data}; pops the RX byte.
  - 0x08 W tx data.
  - 0x10 R cycle_cnt.
  - 0x14 R instr_cnt.
  - 0x18 W clears both counters.
  - Any other offset: reads return 0; writes are ignored.
- Latency: 1 cycle. On each edge with stall=0:
  - mem_out_sel <= req_addr[31:28].
  - uart_out <= decoded read value when hit&&req_re, else 0.
- With stall=1, uart_out and mem_out_sel hold their values, and there is no RX pop, TX load or counter clear.
- RX handshake: uart_rx_ready = hit&&req_re&&offset==0x04&&uart_rx_valid&&!stall, asserted in the same cycle.
  - The byte is captured into uart_out at that edge.
  - Reading 0x04 with rx_valid=0 returns 0 and does not pop.
- TX state machine, states IDLE and PEND (tx_pending=1); uart_tx_valid = tx_pending.
  - IDLE: a write to 0x08 (hit&&req_we&&!stall) loads uart_tx_data<=req_wdata[7:0] and goes to PEND.
  - PEND: on uart_tx_valid&&uart_tx_ready, go to IDLE.
  - Write in PEND with TX_DROP_ON_BUSY=1: dropped. With 0: uart_tx_data is updated and the state stays PEND.
  - Write in the same cycle as acceptance: the accepted byte is the old byte; the new byte is loaded and the state stays PEND.
- Counters:
  - cycle_cnt increments every cycle, including stall cycles.
  - instr_cnt increments when instr_retire=1.
  - Both wrap modulo 2^CNT_W.
  - A write to 0x18 sets both to 0 at the next edge; clear beats increment.
  - A read in the same cycle returns the pre-edge value.
- req_re and req_we both set: the write takes effect and uart_out gets the read value.
- Reset mid-transfer: a pending TX byte is lost; uart_tx_valid deasserts immediately.

Optional Feature:
MMIO_BRANCH_CNT_EN. When defined:
- Adds inputs branch_valid (1) and branch_correct (1).
- Adds counters br_cnt (counts branch_valid) and br_ok_cnt (counts branch_valid&&branch_correct).
- Read at 0x1C (br_cnt) and 0x20 (br_ok_cnt); cleared by 0x18; reset 0.

When undefined, those ports and counters are absent and 0x1C/0x20 read 0.

Decomposition:
- Shared package/header holds:
  - MMIO_REGION (4'b1000) and BIOS/DMEM region nibbles.
  - Offset constants: OFF_STATUS, OFF_RX, OFF_TX, OFF_CYC, OFF_INST, OFF_CLR, OFF_BR, OFF_BROK.
  - TX state encoding.
- One natural sub-module: mmio_counter, a CNT_W counter with inc/clr (clear priority), instantiated 2 or 4 times.

Test Plan:
- Reset, then read 0x80000010 on the 5th post-reset edge -> uart_out=4 one cycle later; mem_out_sel=4'b1000.
- uart_rx_valid=1, uart_rx_data=0x5A, read 0x80000004 -> uart_rx_ready=1 that cycle, uart_out=0x0000005A next cycle. Repeat with rx_valid=0 -> uart_out=0, no pop.
- Write 0x41 to 0x80000008 with uart_tx_ready=0 for 3 cycles:
  - uart_tx_valid=1 and status reads 0x2 (with rx_valid=1).
  - A second write of 0x42 is dropped.
  - Raise ready -> 0x41 accepted, valid drops next cycle.
- Retire 7 instructions, write 0x80000018 in the same cycle as a retire -> instr_cnt=0 and cycle_cnt=0 after the edge. Preload cycle_cnt=0xFFFFFFFF -> wraps to 0.
- Hold stall=1 during a 0x80000004 read with rx_valid=1 -> no uart_rx_ready, and uart_out/mem_out_sel hold prior values.
- Assert rst mid-PEND with a read in flight -> uart_tx_valid=0 and uart_out=0 immediately, before any clock edge.

Source files
------------

// File: rtl/mmio_ctrl_pkg.sv
// Shared constants for the MMIO controller: region nibbles, register
// offsets and the TX state encoding.
package mmio_ctrl_pkg;

  localparam logic [3:0] MMIO_REGION = 4'b1000;
  localparam logic [3:0] BIOS_REGION = 4'b0100;
  localparam logic [3:0] DMEM_REGION = 4'b0001;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYC    = 8'h10;
  localparam logic [7:0] OFF_INST   = 8'h14;
  localparam logic [7:0] OFF_CLR    = 8'h18;
  localparam logic [7:0] OFF_BR     = 8'h1C;
  localparam logic [7:0] OFF_BROK   = 8'h20;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_e;

  // Word-aligned register offset; the byte lane bits never select a register.
  function automatic logic [7:0] word_offset(input logic [31:0] addr);
    return {addr[7:2], 2'b00};
  endfunction

endpackage

// File: rtl/mmio_counter.sv
// Free-running event counter with synchronous clear; clear wins over
// increment so a clear written alongside an event always lands at zero.
module mmio_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count register: wraps naturally modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller for the 0x8xxx_xxxx region: UART RX/TX handshakes,
// cycle/instruction counters and the registered read path into writeback.
// Optional branch counters are built when MMIO_BRANCH_CNT_EN is defined.
//
// TX FSM:
//   state   | meaning
//   TX_IDLE | no byte waiting, TX slot free
//   TX_PEND | uart_tx_data holds a byte the UART has not taken yet
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W           = 32,
  parameter bit          TX_DROP_ON_BUSY = 1'b1
) (
`ifdef MMIO_BRANCH_CNT_EN
  input  logic        branch_valid,
  input  logic        branch_correct,
`endif
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] req_addr,
  input  logic        req_re,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic        instr_retire,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic [31:0] uart_out,
  output logic [3:0]  mem_out_sel
);

  logic [7:0]       off;
  logic             hit;
  logic             rd_hit;
  logic             wr_hit;
  logic             tx_wr;
  logic             cnt_clr;
  logic [31:0]      rd_data;
  logic [31:0]      uart_out_d;
  logic [31:0]      uart_out_q;
  logic [3:0]       mem_out_sel_q;
  tx_state_e        tx_state_q;
  logic [7:0]       tx_data_q;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             unused_ok;

  assign off    = word_offset(req_addr);
  assign hit    = (req_addr[31:28] == MMIO_REGION);
  assign rd_hit = hit && req_re;
  assign wr_hit = hit && req_we && !stall;

  assign tx_wr   = wr_hit && (off == OFF_TX);
  assign cnt_clr = wr_hit && (off == OFF_CLR);

  assign uart_rx_ready = rd_hit && (off == OFF_RX) && uart_rx_valid && !stall;

  assign unused_ok = ^{req_addr[27:8], req_addr[1:0], req_wdata[31:8]};

  mmio_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (1'b1),
    .clr_i (cnt_clr),
    .cnt_o (cycle_cnt)
  );

  mmio_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (instr_retire),
    .clr_i (cnt_clr),
    .cnt_o (instr_cnt)
  );

`ifdef MMIO_BRANCH_CNT_EN
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] br_ok_cnt;

  mmio_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (branch_valid),
    .clr_i (cnt_clr),
    .cnt_o (br_cnt)
  );

  mmio_counter #(.CNT_W(CNT_W)) u_br_ok_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (branch_valid && branch_correct),
    .clr_i (cnt_clr),
    .cnt_o (br_ok_cnt)
  );
`endif

  // Read decode; RX data reads as zero when no byte is waiting.
  always_comb begin
    rd_data = '0;
    case (off)
      OFF_STATUS: rd_data = {30'b0, uart_rx_valid, (tx_state_q != TX_PEND)};
      OFF_RX:     rd_data = uart_rx_valid ? {24'b0, uart_rx_data} : 32'b0;
      OFF_CYC:    rd_data = 32'(cycle_cnt);
      OFF_INST:   rd_data = 32'(instr_cnt);
`ifdef MMIO_BRANCH_CNT_EN
      OFF_BR:     rd_data = 32'(br_cnt);
      OFF_BROK:   rd_data = 32'(br_ok_cnt);
`endif
      default:    rd_data = '0;
    endcase
  end

  assign uart_out_d = rd_hit ? rd_data : 32'b0;

  // Writeback-facing registers; frozen while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_out_q    <= '0;
      mem_out_sel_q <= '0;
    end else if (!stall) begin
      uart_out_q    <= uart_out_d;
      mem_out_sel_q <= req_addr[31:28];
    end
  end

  // TX FSM: a write coinciding with acceptance refills the slot, otherwise
  // a write while pending is dropped or overwrites depending on TX_DROP_ON_BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_data_q  <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_wr) begin
            tx_data_q  <= req_wdata[7:0];
            tx_state_q <= TX_PEND;
          end
        end
        TX_PEND: begin
          if (uart_tx_ready) begin
            if (tx_wr) tx_data_q  <= req_wdata[7:0];
            else       tx_state_q <= TX_IDLE;
          end else if (tx_wr && !TX_DROP_ON_BUSY) begin
            tx_data_q <= req_wdata[7:0];
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign uart_tx_valid = (tx_state_q == TX_PEND);
  assign uart_tx_data  = tx_data_q;
  assign uart_out      = uart_out_q;
  assign mem_out_sel   = mem_out_sel_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl: a vector table walked cycle by cycle from
// reset, then hand sequences for TX overwrite, async reset mid-transfer and
// counter wrap on a narrow second instance.
module tb_mmio_ctrl;

  localparam logic [31:0] R = 32'h8000_0000;

  typedef struct {
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic        ret;
    logic        stl;
    logic        e_rx_ready;
    logic [31:0] e_out;
    logic [3:0]  e_sel;
    logic        e_tx_valid;
    logic [7:0]  e_tx_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] req_addr;
  logic        req_re;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        instr_retire;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_tx_ready;

  logic        uart_rx_ready,   w_rx_ready;
  logic [7:0]  uart_tx_data,    w_tx_data;
  logic        uart_tx_valid,   w_tx_valid;
  logic [31:0] uart_out,        w_out;
  logic [3:0]  mem_out_sel,     w_sel;

  int checks = 0;
  int errors = 0;

  vec_t tbl[42];

  always #5 clk = ~clk;

  mmio_ctrl dut (
`ifdef MMIO_BRANCH_CNT_EN
    .branch_valid   (1'b0),
    .branch_correct (1'b0),
`endif
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .req_addr       (req_addr),
    .req_re         (req_re),
    .req_we         (req_we),
    .req_wdata      (req_wdata),
    .instr_retire   (instr_retire),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_valid  (uart_rx_valid),
    .uart_rx_ready  (uart_rx_ready),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_valid  (uart_tx_valid),
    .uart_tx_ready  (uart_tx_ready),
    .uart_out       (uart_out),
    .mem_out_sel    (mem_out_sel)
  );

  // Narrow counters and overwrite-on-busy TX, sharing every input.
  mmio_ctrl #(.CNT_W(3), .TX_DROP_ON_BUSY(1'b0)) dut_w (
`ifdef MMIO_BRANCH_CNT_EN
    .branch_valid   (1'b0),
    .branch_correct (1'b0),
`endif
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .req_addr       (req_addr),
    .req_re         (req_re),
    .req_we         (req_we),
    .req_wdata      (req_wdata),
    .instr_retire   (instr_retire),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_valid  (uart_rx_valid),
    .uart_rx_ready  (w_rx_ready),
    .uart_tx_data   (w_tx_data),
    .uart_tx_valid  (w_tx_valid),
    .uart_tx_ready  (uart_tx_ready),
    .uart_out       (w_out),
    .mem_out_sel    (w_sel)
  );

  function automatic vec_t mk(
    input logic [31:0] addr, input logic re, input logic we, input logic [31:0] wdata,
    input logic rxv, input logic [7:0] rxd, input logic txr, input logic ret, input logic stl,
    input logic erx, input logic [31:0] eout, input logic [3:0] esel,
    input logic etxv, input logic [7:0] etxd);
    vec_t v;
    v.addr = addr; v.re = re; v.we = we; v.wdata = wdata;
    v.rxv = rxv; v.rxd = rxd; v.txr = txr; v.ret = ret; v.stl = stl;
    v.e_rx_ready = erx; v.e_out = eout; v.e_sel = esel;
    v.e_tx_valid = etxv; v.e_tx_data = etxd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_addr      = v.addr;
    req_re        = v.re;
    req_we        = v.we;
    req_wdata     = v.wdata;
    uart_rx_valid = v.rxv;
    uart_rx_data  = v.rxd;
    uart_tx_ready = v.txr;
    instr_retire  = v.ret;
    stall         = v.stl;
  endtask

  // Apply one vector for one clock: combinational check before the edge,
  // registered checks just after it.
  task automatic step(input vec_t v, input string tag);
    drive(v);
    #1;
    chk({tag, " rx_ready"}, {31'b0, uart_rx_ready}, {31'b0, v.e_rx_ready});
    @(posedge clk);
    #1;
    chk({tag, " uart_out"}, uart_out, v.e_out);
    chk({tag, " mem_out_sel"}, {28'b0, mem_out_sel}, {28'b0, v.e_sel});
    chk({tag, " tx_valid"}, {31'b0, uart_tx_valid}, {31'b0, v.e_tx_valid});
    chk({tag, " tx_data"}, {24'b0, uart_tx_data}, {24'b0, v.e_tx_data});
  endtask

  initial begin
    // addr re we wdata rxv rxd txr ret stl | rx_ready out sel tx_valid tx_data
    for (int i = 0; i < 4; i++)
      tbl[i] = mk(32'h0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'h0, 4'h0, 0, 8'h00);
    tbl[4]  = mk(R | 32'h10, 1, 0, 0,     0, 8'h00, 0, 0, 0, 0, 32'h4,  4'h8, 0, 8'h00);
    tbl[5]  = mk(R | 32'h04, 1, 0, 0,     1, 8'h5A, 0, 0, 0, 1, 32'h5A, 4'h8, 0, 8'h00);
    tbl[6]  = mk(R | 32'h04, 1, 0, 0,     0, 8'h5A, 0, 0, 0, 0, 32'h0,  4'h8, 0, 8'h00);
    tbl[7]  = mk(R | 32'h08, 0, 1, 32'h41, 0, 8'h00, 0, 0, 0, 0, 32'h0, 4'h8, 1, 8'h41);
    tbl[8]  = mk(R | 32'h00, 1, 0, 0,     1, 8'h00, 0, 0, 0, 0, 32'h2,  4'h8, 1, 8'h41);
    tbl[9]  = mk(R | 32'h08, 0, 1, 32'h42, 1, 8'h00, 0, 0, 0, 0, 32'h0, 4'h8, 1, 8'h41);
    tbl[10] = mk(32'h0,      0, 0, 0,     0, 8'h00, 0, 0, 0, 0, 32'h0,  4'h0, 1, 8'h41);
    tbl[11] = mk(32'h0,      0, 0, 0,     0, 8'h00, 1, 0, 0, 0, 32'h0,  4'h0, 0, 8'h41);
    tbl[12] = mk(R | 32'h08, 0, 1, 32'h43, 0, 8'h00, 1, 0, 0, 0, 32'h0, 4'h8, 1, 8'h43);
    tbl[13] = mk(R | 32'h08, 0, 1, 32'h44, 0, 8'h00, 1, 0, 0, 0, 32'h0, 4'h8, 1, 8'h44);
    tbl[14] = mk(32'h0,      0, 0, 0,     0, 8'h00, 1, 0, 0, 0, 32'h0,  4'h0, 0, 8'h44);
    for (int i = 15; i < 22; i++)
      tbl[i] = mk(32'h0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 32'h0, 4'h0, 0, 8'h44);
    tbl[22] = mk(R | 32'h14, 1, 0, 0,     0, 8'h00, 0, 0, 0, 0, 32'h7,  4'h8, 0, 8'h44);
    tbl[23] = mk(R | 32'h10, 1, 0, 0,     0, 8'h00, 0, 0, 0, 0, 32'h17, 4'h8, 0, 8'h44);
    tbl[24] = mk(R | 32'h18, 0, 1, 0,     0, 8'h00, 0, 1, 0, 0, 32'h0,  4'h8, 0, 8'h44);
    tbl[25] = mk(R | 32'h14, 1, 0, 0,     0, 8'h00, 0, 0, 0, 0, 32'h0,  4'h8, 0, 8'h44);
    tbl[26] = mk(R | 32'h10, 1, 0, 0,     0, 8'h00, 0, 0, 0, 0, 32'h1,  4'h8, 0, 8'h44);
    tbl[27] = mk(R | 32'h08, 1, 1, 32'h55, 0, 8'h00, 0, 0, 0, 0, 32'h0, 4'h8, 1, 8'h55);
    tbl[28] = mk(R | 32'h00, 1, 0, 0,     0, 8'h00, 0, 0, 0, 0, 32'h0,  4'h8, 1, 8'h55);
    tbl[29] = mk(R | 32'h10, 1, 0, 0,     0, 8'h00, 0, 0, 0, 0, 32'h4,  4'h8, 1, 8'h55);
    tbl[30] = mk(R | 32'h04, 1, 0, 0,     1, 8'h77, 0, 0, 1, 0, 32'h4,  4'h8, 1, 8'h55);
    tbl[31] = mk(32'h1000_0010, 1, 0, 0,  0, 8'h00, 0, 0, 1, 0, 32'h4,  4'h8, 1, 8'h55);
    tbl[32] = mk(R | 32'h18, 0, 1, 0,     0, 8'h00, 0, 0, 1, 0, 32'h4,  4'h8, 1, 8'h55);
    tbl[33] = mk(R | 32'h10, 1, 0, 0,     0, 8'h00, 0, 0, 0, 0, 32'h8,  4'h8, 1, 8'h55);
    tbl[34] = mk(32'h0,      0, 0, 0,     0, 8'h00, 1, 0, 0, 0, 32'h0,  4'h0, 0, 8'h55);
    tbl[35] = mk(R | 32'h08, 0, 1, 32'h66, 0, 8'h00, 0, 0, 1, 0, 32'h0, 4'h0, 0, 8'h55);
    tbl[36] = mk(R | 32'h1C, 1, 0, 0,     0, 8'h00, 0, 0, 0, 0, 32'h0,  4'h8, 0, 8'h55);
    tbl[37] = mk(R | 32'h0C, 1, 0, 0,     0, 8'h00, 0, 0, 0, 0, 32'h0,  4'h8, 0, 8'h55);
    tbl[38] = mk(32'h0000_0010, 1, 0, 0,  0, 8'h00, 0, 0, 0, 0, 32'h0,  4'h0, 0, 8'h55);
    tbl[39] = mk(R | 32'h13, 1, 0, 0,     0, 8'h00, 0, 0, 0, 0, 32'hE,  4'h8, 0, 8'h55);
    tbl[40] = mk(R | 32'h20, 1, 0, 0,     0, 8'h00, 0, 0, 0, 0, 32'h0,  4'h8, 0, 8'h55);
    tbl[41] = mk(R | 32'h00, 1, 0, 0,     1, 8'h00, 0, 0, 0, 0, 32'h3,  4'h8, 0, 8'h55);

    rst = 1'b1;
    drive(tbl[0]);
    #1;
    chk("reset uart_out", uart_out, 32'h0);
    chk("reset mem_out_sel", {28'b0, mem_out_sel}, 32'h0);
    chk("reset tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    chk("reset tx_data", {24'b0, uart_tx_data}, 32'h0);
    chk("reset rx_ready", {31'b0, uart_rx_ready}, 32'h0);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 42; i++)
      step(tbl[i], $sformatf("v%0d", i));

    // TX byte overwritten while pending only on the overwrite-on-busy instance.
    step(mk(R | 32'h08, 0, 1, 32'h41, 0, 8'h00, 0, 0, 0, 0, 32'h0, 4'h8, 1, 8'h41), "h1");
    chk("h1 w tx_data", {24'b0, w_tx_data}, 32'h41);
    step(mk(R | 32'h08, 0, 1, 32'h42, 0, 8'h00, 0, 0, 0, 0, 32'h0, 4'h8, 1, 8'h41), "h2");
    chk("h2 w tx_data", {24'b0, w_tx_data}, 32'h42);
    chk("h2 w tx_valid", {31'b0, w_tx_valid}, 32'h1);
    step(mk(R | 32'h10, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'h13, 4'h8, 1, 8'h41), "h3");
    chk("h3 w uart_out", w_out, 32'h3);

    // Async reset while TX pending and a read is in flight.
    drive(mk(R | 32'h14, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'h0, 4'h0, 0, 8'h00));
    #2;
    rst = 1'b1;
    #1;
    chk("rst tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    chk("rst uart_out", uart_out, 32'h0);
    chk("rst mem_out_sel", {28'b0, mem_out_sel}, 32'h0);
    chk("rst tx_data", {24'b0, uart_tx_data}, 32'h0);
    chk("rst w tx_valid", {31'b0, w_tx_valid}, 32'h0);
    #1;
    rst = 1'b0;

    // Counter wrap on the 3-bit instance.
    for (int i = 0; i < 7; i++)
      step(mk(32'h0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'h0, 4'h0, 0, 8'h00), $sformatf("w%0d", i));
    step(mk(R | 32'h10, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'h7, 4'h8, 0, 8'h00), "wrap7");
    chk("wrap7 w uart_out", w_out, 32'h7);
    step(mk(R | 32'h10, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'h8, 4'h8, 0, 8'h00), "wrap8");
    chk("wrap8 w uart_out", w_out, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
